// File: rtl/alu_scheduler_pkg.sv
// Shared FSM encodings and ALU opcode values for the scheduler slice.
package alu_scheduler_pkg;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_RESPOND = 2'd3;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;

endpackage

// File: rtl/alu_scheduler_if.sv
// Two-port request/response bundle between requesters and the scheduler.
interface alu_scheduler_if #(
    parameter int WORD_SIZE   = 16,
    parameter int OPCODE_SIZE = 4
);
    logic [1:0]               req_valid;
    logic [1:0]               req_ready;
    logic [2*OPCODE_SIZE-1:0] req_opcode;
    logic [2*WORD_SIZE-1:0]   req_a;
    logic [2*WORD_SIZE-1:0]   req_b;
    logic [1:0]               rsp_valid;
    logic [1:0]               rsp_ready;
    logic [WORD_SIZE-1:0]     rsp_data;

    modport master (
        output req_valid, req_opcode, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_opcode, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/alu.sv
// Registered, enable-gated ALU; unknown opcodes evaluate to zero.
module alu
    import alu_scheduler_pkg::*;
#(
    parameter int WORD_SIZE   = 16,
    parameter int OPCODE_SIZE = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   alu_enable,
    input  logic [OPCODE_SIZE-1:0] opcode,
    input  logic [WORD_SIZE-1:0]   input1,
    input  logic [WORD_SIZE-1:0]   input2,
    output logic [WORD_SIZE-1:0]   alu_out
);
    logic [WORD_SIZE-1:0] result;

    always_comb begin
        result = '0;
        case (opcode)
            OP_ADD:  result = input1 + input2;
            OP_SUB:  result = input1 - input2;
            OP_AND:  result = input1 & input2;
            OP_OR:   result = input1 | input2;
            OP_XOR:  result = input1 ^ input2;
            default: result = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            alu_out <= '0;
        else if (alu_enable)
            alu_out <= result;
    end
endmodule

// File: rtl/alu_scheduler_rr_arbiter_2.sv
// Two-way round-robin arbiter; last_grant advances only on an accept.
module rr_arbiter_2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt,
    output logic       gnt_idx
);
    logic last_grant;

    // On a tie the port that did not win last time goes first.
    assign gnt_idx = (&req) ? ~last_grant : req[1];
    assign gnt     = (|req) ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            last_grant <= 1'b1;
        else if (accept)
            last_grant <= gnt_idx;
    end
endmodule

// File: rtl/alu_scheduler.sv
// Round-robin two-port front end that sequences one ALU op at a time.
module alu_scheduler
    import alu_scheduler_pkg::*;
#(
    parameter int WORD_SIZE   = 16,
    parameter int OPCODE_SIZE = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    alu_scheduler_if.slave         bus,
    output logic                   alu_enable,
    output logic [OPCODE_SIZE-1:0] alu_opcode,
    output logic [WORD_SIZE-1:0]   alu_input1,
    output logic [WORD_SIZE-1:0]   alu_input2,
    input  logic [WORD_SIZE-1:0]   alu_out,
    output logic                   busy
);
    logic [1:0]             state;
    logic [1:0]             state_nxt;
    logic [OPCODE_SIZE-1:0] op_opcode;
    logic [WORD_SIZE-1:0]   op_a;
    logic [WORD_SIZE-1:0]   op_b;
    logic                   grant;
    logic [WORD_SIZE-1:0]   res_q;
    logic [1:0]             arb_gnt;
    logic                   arb_idx;
    logic                   idle;
    logic                   accept;
    logic [OPCODE_SIZE-1:0] sel_opcode;
    logic [WORD_SIZE-1:0]   sel_a;
    logic [WORD_SIZE-1:0]   sel_b;

    assign idle   = (state == S_IDLE);
    assign accept = idle & (|bus.req_valid);

    rr_arbiter_2 u_arb (
        .clock   (clock),
        .reset   (reset),
        .req     (bus.req_valid),
        .accept  (accept),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    assign sel_opcode = arb_idx ? bus.req_opcode[2*OPCODE_SIZE-1:OPCODE_SIZE]
                                : bus.req_opcode[OPCODE_SIZE-1:0];
    assign sel_a = arb_idx ? bus.req_a[2*WORD_SIZE-1:WORD_SIZE]
                           : bus.req_a[WORD_SIZE-1:0];
    assign sel_b = arb_idx ? bus.req_b[2*WORD_SIZE-1:WORD_SIZE]
                           : bus.req_b[WORD_SIZE-1:0];

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:    if (accept) state_nxt = S_ISSUE;
            S_ISSUE:   state_nxt = S_WAIT;
            S_WAIT:    state_nxt = S_RESPOND;
            S_RESPOND: if (bus.rsp_ready[grant]) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_opcode <= '0;
            op_a      <= '0;
            op_b      <= '0;
            grant     <= 1'b0;
            res_q     <= '0;
        end else begin
            if (accept) begin
                op_opcode <= sel_opcode;
                op_a      <= sel_a;
                op_b      <= sel_b;
                grant     <= arb_idx;
            end
            if (state == S_WAIT)
                res_q <= alu_out;
        end
    end

    assign bus.req_ready = idle ? arb_gnt : 2'b00;
    assign bus.rsp_valid = (state == S_RESPOND) ? (grant ? 2'b10 : 2'b01)
                                                : 2'b00;
    assign bus.rsp_data  = res_q;
    assign alu_enable    = (state == S_ISSUE);
    assign alu_opcode    = op_opcode;
    assign alu_input1    = op_a;
    assign alu_input2    = op_b;
    assign busy          = ~idle;
endmodule

// File: tb/tb_alu_scheduler.sv
// Directed vector bench for alu_scheduler driving the registered alu.
module tb_alu_scheduler;
    import alu_scheduler_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        alu_enable;
    logic [3:0]  alu_opcode;
    logic [15:0] alu_input1;
    logic [15:0] alu_input2;
    logic [15:0] alu_out;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    alu_scheduler_if #(.WORD_SIZE(16), .OPCODE_SIZE(4)) bus ();

    alu_scheduler #(.WORD_SIZE(16), .OPCODE_SIZE(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .alu_enable (alu_enable),
        .alu_opcode (alu_opcode),
        .alu_input1 (alu_input1),
        .alu_input2 (alu_input2),
        .alu_out    (alu_out),
        .busy       (busy)
    );

    alu #(.WORD_SIZE(16), .OPCODE_SIZE(4)) u_alu (
        .clock      (clock),
        .reset      (reset),
        .alu_enable (alu_enable),
        .opcode     (alu_opcode),
        .input1     (alu_input1),
        .input2     (alu_input2),
        .alu_out    (alu_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        port;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic load(input logic port, input logic [3:0] op,
                        input logic [15:0] a, input logic [15:0] b);
        if (port) begin
            bus.req_opcode[7:4] = op;
            bus.req_a[31:16]    = a;
            bus.req_b[31:16]    = b;
        end else begin
            bus.req_opcode[3:0] = op;
            bus.req_a[15:0]     = a;
            bus.req_b[15:0]     = b;
        end
    endtask

    task automatic run_op(input vec_t v);
        logic [1:0] one;
        int n;
        int en;
        one = v.port ? 2'b10 : 2'b01;
        @(negedge clock);
        load(v.port, v.op, v.a, v.b);
        bus.req_valid = one;
        bus.rsp_ready = 2'b11;
        #1 check("accept", {30'd0, bus.req_ready}, {30'd0, one});
        @(negedge clock);
        bus.req_valid = 2'b00;
        n = 1;
        en = alu_enable ? 1 : 0;
        while (bus.rsp_valid == 2'b00 && n < 8) begin
            @(negedge clock);
            n++;
            if (alu_enable) en++;
        end
        check("latency", n, 3);
        check("enable_cycles", en, 1);
        check("rsp_valid", {30'd0, bus.rsp_valid}, {30'd0, one});
        check("rsp_data", {16'd0, bus.rsp_data}, {16'd0, v.exp});
        @(negedge clock);
        check("idle_after", {30'd0, busy, bus.rsp_valid[0] | bus.rsp_valid[1]}, 0);
        bus.rsp_ready = 2'b00;
    endtask

    initial begin
        logic [1:0]  gexp;
        logic [15:0] dexp;
        int n;

        tbl[0] = '{1'b0, OP_ADD, 16'h0003, 16'h0004, 16'h0007};
        tbl[1] = '{1'b1, OP_SUB, 16'h0010, 16'h0001, 16'h000F};
        tbl[2] = '{1'b0, OP_OR,  16'h1200, 16'h0034, 16'h1234};
        tbl[3] = '{1'b1, OP_ADD, 16'hFFFF, 16'h0001, 16'h0000};
        tbl[4] = '{1'b0, OP_XOR, 16'hAAAA, 16'h5555, 16'hFFFF};
        tbl[5] = '{1'b1, 4'hF,   16'h1234, 16'h5678, 16'h0000};

        reset = 1'b1;
        bus.req_valid  = 2'b00;
        bus.rsp_ready  = 2'b00;
        bus.req_opcode = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;

        #12;
        check("rst_rsp_valid", {30'd0, bus.rsp_valid}, 0);
        check("rst_rsp_data", {16'd0, bus.rsp_data}, 0);
        check("rst_alu_enable", {31'd0, alu_enable}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_alu_in", {alu_input1, alu_input2}, 0);
        check("rst_alu_opcode", {28'd0, alu_opcode}, 0);
        bus.req_valid = 2'b11;
        #1 check("rst_first_tie", {30'd0, bus.req_ready}, 32'd1);
        bus.req_valid = 2'b00;
        @(negedge clock);
        reset = 1'b0;

        foreach (tbl[i]) run_op(tbl[i]);

        // Tie: both ports continuously valid, grants must alternate.
        @(negedge clock);
        load(1'b0, OP_AND, 16'hF0F0, 16'h0FF0);
        load(1'b1, OP_XOR, 16'hFFFF, 16'h00FF);
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            gexp = (k % 2 == 0) ? 2'b01 : 2'b10;
            dexp = (k % 2 == 0) ? 16'h00F0 : 16'hFF00;
            n = 0;
            while (bus.req_ready == 2'b00 && n < 10) begin
                @(negedge clock); #1; n++;
            end
            check("tie_grant", {30'd0, bus.req_ready}, {30'd0, gexp});
            n = 0;
            while (bus.rsp_valid == 2'b00 && n < 10) begin
                @(negedge clock); #1; n++;
            end
            check("tie_rsp_valid", {30'd0, bus.rsp_valid}, {30'd0, gexp});
            check("tie_rsp_data", {16'd0, bus.rsp_data}, {16'd0, dexp});
            check("tie_no_ready_in_rsp", {30'd0, bus.req_ready}, 0);
            @(negedge clock); #1;
        end
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;

        // Backpressure on port 0 while port 1 waits.
        @(negedge clock);
        load(1'b0, OP_ADD, 16'h0100, 16'h0023);
        bus.req_valid = 2'b01;
        @(negedge clock);
        load(1'b1, OP_XOR, 16'h00FF, 16'h0F0F);
        bus.req_valid = 2'b10;
        n = 0;
        while (bus.rsp_valid == 2'b00 && n < 10) begin
            @(negedge clock); n++;
        end
        for (int k = 0; k < 5; k++) begin
            check("bp_rsp_valid", {30'd0, bus.rsp_valid}, 32'd1);
            check("bp_rsp_data", {16'd0, bus.rsp_data}, 32'h0123);
            check("bp_req_ready", {30'd0, bus.req_ready}, 0);
            @(negedge clock);
        end
        bus.rsp_ready = 2'b01;
        @(negedge clock);
        bus.rsp_ready = 2'b00;
        #1 check("bp_next_accept", {30'd0, bus.req_ready}, 32'd2);
        @(negedge clock);
        bus.req_valid = 2'b00;

        // Port 1 granted; only port 0 signals ready.
        bus.rsp_ready = 2'b01;
        n = 0;
        while (bus.rsp_valid == 2'b00 && n < 10) begin
            @(negedge clock); n++;
        end
        check("wp_rsp_data", {16'd0, bus.rsp_data}, 32'h0FF0);
        for (int k = 0; k < 3; k++) begin
            check("wp_hold", {30'd0, bus.rsp_valid}, 32'd2);
            @(negedge clock);
        end
        check("wp_busy", {31'd0, busy}, 32'd1);
        bus.rsp_ready = 2'b10;
        @(negedge clock);
        check("wp_release", {31'd0, busy}, 0);
        bus.rsp_ready = 2'b00;

        // Reset while the op sits in WAIT.
        load(1'b0, OP_ADD, 16'h0001, 16'h0001);
        bus.req_valid = 2'b01;
        @(negedge clock);
        bus.req_valid = 2'b00;
        @(negedge clock);
        check("rw_busy_pre", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rw_rsp_valid", {30'd0, bus.rsp_valid}, 0);
        check("rw_alu_enable", {31'd0, alu_enable}, 0);
        check("rw_busy", {31'd0, busy}, 0);
        check("rw_rsp_data", {16'd0, bus.rsp_data}, 0);
        check("rw_alu_in", {alu_input1, alu_input2}, 0);
        @(negedge clock);
        reset = 1'b0;
        run_op('{1'b1, OP_ADD, 16'h0002, 16'h0003, 16'h0005});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
